ff2_sync_p: RTL and testbench

- Multi-stage flip-flop synchronizer for bringing asynchronous level signals (state flags, handshake req/ack) into a destination clock domain.
- Samples on the rising edge of the destination clock and passes the input through a chain of STAGES registers; the output is the last stage.
- Used on both sides of a two-flag req/ack handshake between unrelated clock domains.
- Carries no data-coherency guarantee for WIDTH > 1; each bit is synchronized independently.

---
 rtl/ff2_sync_pkg.sv | 12 +
 rtl/sync_cell.sv | 28 ++
 rtl/ff2_sync_p.sv | 50 +++++
 tb/tb_ff2_sync_p.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ff2_sync_pkg.sv
// Shared constants and elaboration helpers for the ff2_sync_p synchronizer family.
package ff2_sync_pkg;

    localparam int SYNC_MIN_STAGES     = 2;
    localparam int SYNC_DEFAULT_STAGES = 2;

    // Fewer than two flops gives no time for a metastable first stage to settle.
    function automatic bit sync_stages_valid(input int stages);
        return stages >= SYNC_MIN_STAGES;
    endfunction

endpackage

// File: rtl/sync_cell.sv
// Single-bit STAGES-deep flip-flop synchronizer chain with synchronous active-low reset.
module sync_cell
    import ff2_sync_pkg::*;
#(
    parameter int   STAGES    = SYNC_DEFAULT_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (!sync_stages_valid(STAGES)) begin : g_bad_stages
        $error("sync_cell: STAGES=%0d is below the minimum of %0d", STAGES, SYNC_MIN_STAGES);
    end

    // Pure shift chain: nothing may sit between the flops or settling time is lost.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= {STAGES{RESET_VAL}};
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ff2_sync_p.sv
// WIDTH-bit multi-stage level synchronizer; each bit crosses independently.
// Define FF2SYNC_EDGE_DET_EN to add registered-derived rise/fall pulse outputs.
module ff2_sync_p
    import ff2_sync_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = SYNC_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
`ifdef FF2SYNC_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    if (!sync_stages_valid(STAGES)) begin : g_bad_stages
        $error("ff2_sync_p: STAGES=%0d is below the minimum of %0d", STAGES, SYNC_MIN_STAGES);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_cell #(
            .STAGES   (STAGES),
            .RESET_VAL(RESET_VAL[i])
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (d[i]),
            .q    (q[i])
        );
    end

`ifdef FF2SYNC_EDGE_DET_EN
    // q_prev resets with the chain so no spurious edge appears right after reset.
    logic [WIDTH-1:0] q_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) q_prev <= RESET_VAL;
        else        q_prev <= q;
    end

    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;
`endif

endmodule

// File: tb/tb_ff2_sync_p.sv
// Scoreboard bench for ff2_sync_p: directed vectors on three configurations plus a req/ack loop.
`timescale 1ns/1ps
module tb_ff2_sync_p;

    typedef struct {
        int         dut;
        logic [2:0] q;
        logic       rise;
        logic       fall;
        string      name;
    } exp_t;

    localparam int HS_N = 4;

    logic clk = 1'b0, clk_a = 1'b0, clk_b = 1'b0;
    always #5    clk   = ~clk;
    always #50   clk_a = ~clk_a;
    always #5500 clk_b = ~clk_b;

    int checks = 0, failures = 0;
    exp_t sb[$];
    logic hs_q[$];
    int hs_seen = 0;

    // DUT 0: WIDTH=1 STAGES=2 RESET_VAL=0
    logic rst0 = 1'b0; logic [0:0] d0 = '0, q0, rise0, fall0;
    // DUT 1: WIDTH=3 STAGES=4 RESET_VAL=0
    logic rst1 = 1'b0; logic [2:0] d1 = '0, q1, rise1, fall1;
    // DUT 2: WIDTH=1 STAGES=2 RESET_VAL=1
    logic rst2 = 1'b0; logic [0:0] d2 = '0, q2, rise2, fall2;
    // handshake pair
    logic rst_a = 1'b0, rst_b = 1'b0;
    logic [0:0] req = '0, ack = '0, req_s, ack_s, hs_r0, hs_f0, hs_r1, hs_f1;

    ff2_sync_p #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0)) u0 (
        .clk(clk), .rst_n(rst0), .d(d0), .q(q0)
`ifdef FF2SYNC_EDGE_DET_EN
        , .rise(rise0), .fall(fall0)
`endif
    );
    ff2_sync_p #(.WIDTH(3), .STAGES(4), .RESET_VAL(3'b000)) u1 (
        .clk(clk), .rst_n(rst1), .d(d1), .q(q1)
`ifdef FF2SYNC_EDGE_DET_EN
        , .rise(rise1), .fall(fall1)
`endif
    );
    ff2_sync_p #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b1)) u2 (
        .clk(clk), .rst_n(rst2), .d(d2), .q(q2)
`ifdef FF2SYNC_EDGE_DET_EN
        , .rise(rise2), .fall(fall2)
`endif
    );
    ff2_sync_p u_req (
        .clk(clk_b), .rst_n(rst_b), .d(req), .q(req_s)
`ifdef FF2SYNC_EDGE_DET_EN
        , .rise(hs_r0), .fall(hs_f0)
`endif
    );
    ff2_sync_p u_ack (
        .clk(clk_a), .rst_n(rst_a), .d(ack), .q(ack_s)
`ifdef FF2SYNC_EDGE_DET_EN
        , .rise(hs_r1), .fall(hs_f1)
`endif
    );

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Drive mid-cycle, then queue what the DUT must show after the next rising edge.
    task automatic step(input int dut, input logic rst, input logic [2:0] d,
                        input logic [2:0] eq, input logic er, input logic ef, input string nm);
        exp_t e;
        @(negedge clk); #1;
        case (dut)
            0: begin rst0 = rst; d0 = d[0]; end
            1: begin rst1 = rst; d1 = d;    end
            default: begin rst2 = rst; d2 = d[0]; end
        endcase
        e.dut = dut; e.q = eq; e.rise = er; e.fall = ef; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per falling edge, i.e. half a cycle after the checked edge.
    initial begin
        exp_t e;
        logic [2:0] aq;
        logic ar, af;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0: begin aq = {2'b00, q0}; ar = rise0[0]; af = fall0[0]; end
                    1: begin aq = q1;          ar = 1'b0;     af = 1'b0;     end
                    default: begin aq = {2'b00, q2}; ar = rise2[0]; af = fall2[0]; end
                endcase
                chk({e.name, ".q"}, aq, e.q);
`ifdef FF2SYNC_EDGE_DET_EN
                if (e.dut != 1) begin
                    chk({e.name, ".rise"}, {2'b00, ar}, {2'b00, e.rise});
                    chk({e.name, ".fall"}, {2'b00, af}, {2'b00, e.fall});
                end
`endif
            end
        end
    end

    // Far-side agent: ack mirrors the synchronized req (four-phase handshake).
    initial forever begin
        @(posedge clk_b); #1;
        ack = rst_b ? req_s : 1'b0;
    end

    // Far-side monitor: every req_s transition must match the next issued req level.
    initial begin
        logic prev;
        logic e;
        prev = 1'b0;
        forever begin
            @(negedge clk_b);
            if (rst_b && req_s[0] !== prev) begin
                if (hs_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL hs.unexpected at %0t: got req_s=%b expected no transition", $time, req_s);
                end else begin
                    e = hs_q.pop_front();
                    chk("hs.req_s", {2'b00, req_s}, {2'b00, e});
                end
                prev = req_s[0];
                hs_seen++;
            end
        end
    end

    initial begin
        int cyc;
        int issued;

        // DUT 0: reset holds q low with d high
        step(0, 0, 3'b1, 3'b0, 0, 0, "u0.rst1");
        step(0, 0, 3'b1, 3'b0, 0, 0, "u0.rst2");
        step(0, 0, 3'b1, 3'b0, 0, 0, "u0.rst3");
        step(0, 1, 3'b1, 3'b0, 0, 0, "u0.rel_e1");
        step(0, 1, 3'b1, 3'b1, 1, 0, "u0.rel_e2");
        step(0, 1, 3'b1, 3'b1, 0, 0, "u0.rel_e3");
        step(0, 1, 3'b1, 3'b1, 0, 0, "u0.hold");
        // falling latency
        step(0, 1, 3'b0, 3'b1, 0, 0, "u0.fall_e1");
        step(0, 1, 3'b0, 3'b0, 0, 1, "u0.fall_e2");
        step(0, 1, 3'b0, 3'b0, 0, 0, "u0.fall_e3");
        // rising latency
        step(0, 1, 3'b1, 3'b0, 0, 0, "u0.rise_e1");
        step(0, 1, 3'b1, 3'b1, 1, 0, "u0.rise_e2");
        step(0, 1, 3'b1, 3'b1, 0, 0, "u0.rise_e3");
        step(0, 1, 3'b0, 3'b1, 0, 0, "u0.back_e1");
        step(0, 1, 3'b0, 3'b0, 0, 1, "u0.back_e2");
        // reset mid-transfer discards the sampled 1
        step(0, 1, 3'b1, 3'b0, 0, 0, "u0.mid_samp");
        step(0, 0, 3'b1, 3'b0, 0, 0, "u0.mid_rst");
        step(0, 1, 3'b0, 3'b0, 0, 0, "u0.mid_a");
        step(0, 1, 3'b0, 3'b0, 0, 0, "u0.mid_b");
        step(0, 1, 3'b0, 3'b0, 0, 0, "u0.mid_c");

        // DUT 1: four-deep, three bits
        step(1, 0, 3'b000, 3'b000, 0, 0, "u1.rst1");
        step(1, 0, 3'b000, 3'b000, 0, 0, "u1.rst2");
        step(1, 1, 3'b101, 3'b000, 0, 0, "u1.e1");
        step(1, 1, 3'b101, 3'b000, 0, 0, "u1.e2");
        step(1, 1, 3'b101, 3'b000, 0, 0, "u1.e3");
        step(1, 1, 3'b101, 3'b101, 0, 0, "u1.e4");
        step(1, 1, 3'b010, 3'b101, 0, 0, "u1.f1");
        step(1, 1, 3'b010, 3'b101, 0, 0, "u1.f2");
        step(1, 1, 3'b010, 3'b101, 0, 0, "u1.f3");
        step(1, 1, 3'b010, 3'b010, 0, 0, "u1.f4");
        step(1, 1, 3'b010, 3'b010, 0, 0, "u1.f5");

        // DUT 2: non-zero reset value
        step(2, 0, 3'b0, 3'b1, 0, 0, "u2.rst1");
        step(2, 0, 3'b0, 3'b1, 0, 0, "u2.rst2");
        step(2, 1, 3'b0, 3'b1, 0, 0, "u2.e1");
        step(2, 1, 3'b0, 3'b0, 0, 1, "u2.e2");
        step(2, 1, 3'b0, 3'b0, 0, 0, "u2.e3");
        step(2, 1, 3'b1, 3'b0, 0, 0, "u2.r1");
        step(2, 1, 3'b1, 3'b1, 1, 0, "u2.r2");
        step(2, 1, 3'b1, 3'b1, 0, 0, "u2.r3");

        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin @(negedge clk); cyc++; end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL sb.drain: got %0d pending expected 0", sb.size());
        end

        // Handshake across 100 ns / 11 us clocks
        repeat (2) @(posedge clk_b);
        @(negedge clk_b);
        rst_a = 1'b1; rst_b = 1'b1;
        issued = 0; cyc = 0;
        while ((issued < HS_N || ack_s !== req) && cyc < 8000) begin
            @(posedge clk_a); #1;
            if (ack_s === req && issued < HS_N) begin
                req = ~req;
                issued++;
                hs_q.push_back(req[0]);
            end
            cyc++;
        end
        if (cyc >= 8000) begin
            checks++; failures++;
            $display("FAIL hs.timeout: got %0d issued expected %0d", issued, HS_N);
        end
        cyc = 0;
        while (hs_seen < HS_N && cyc < 10) begin @(negedge clk_b); cyc++; end
        chk("hs.seen_count", hs_seen[2:0], 3'(HS_N));
        chk("hs.pending", 3'(hs_q.size()), 3'b000);
        chk("hs.final_ack", {2'b00, ack_s}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
